// File: rtl/id_stage_pipe.sv
// id_stage_pipe: 16-bit MIPS decode stage with a bypassed register file, zero-test branch
// resolution, a load-use stall, a one-slot wrong-path squash and the ID/EX register.
`default_nettype none

module id_stage_pipe #(
  parameter int DATA_W     = 16,
  parameter int RADDR_W    = 3,
  parameter int IMM_W      = 6,
  parameter int ST_SRC_LSB = 9,
  parameter int ZERO_REG   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [DATA_W-1:0]  inst,
  input  logic [DATA_W-1:0]  pc,
  input  logic [RADDR_W-1:0] read1_addr,
  input  logic [RADDR_W-1:0] read2_addr,
  input  logic               mem_store,
  input  logic               br_comm,
  input  logic               br_mode,
  input  logic               ex_mem_read,
  input  logic [RADDR_W-1:0] ex_dest_addr,
  input  logic               wb_wr_en,
  input  logic [RADDR_W-1:0] wb_address_input,
  input  logic [DATA_W-1:0]  wb_data_input,
  input  logic [RADDR_W-1:0] test_reg_selector,
  output logic [DATA_W-1:0]  test_selected_reg,
  output logic               stall,
  output logic               br_perform,
  output logic [DATA_W-1:0]  pc_branched,
  output logic               ex_valid,
  output logic [DATA_W-1:0]  ex_inst,
  output logic [DATA_W-1:0]  ex_read1,
  output logic [DATA_W-1:0]  ex_read2,
  output logic [DATA_W-1:0]  ex_imm,
  output logic [DATA_W-1:0]  ex_pc
);

  localparam int NREG = 2 ** RADDR_W;

  logic [DATA_W-1:0]  regs [NREG];
  logic               squash;
  logic [RADDR_W-1:0] src2;
  logic [DATA_W-1:0]  read1;
  logic [DATA_W-1:0]  read2;
  logic [DATA_W-1:0]  imm;
  logic               eff_valid;
  logic               wb_ok;
  logic               zero1;
  logic               zero2;
  logic               dest_zero;
  logic               dest_hit;

  // A write-back to the hard-wired zero register is neither stored nor bypassed.
  assign wb_ok     = wb_wr_en && !((ZERO_REG != 0) && (wb_address_input == '0));
  assign src2      = mem_store ? inst[ST_SRC_LSB +: RADDR_W] : read2_addr;
  assign zero1     = (ZERO_REG != 0) && (read1_addr == '0);
  assign zero2     = (ZERO_REG != 0) && (src2 == '0);
  assign dest_zero = (ZERO_REG != 0) && (ex_dest_addr == '0);

  assign read1 = zero1 ? '0 :
                 (wb_ok && (wb_address_input == read1_addr)) ? wb_data_input : regs[read1_addr];
  assign read2 = zero2 ? '0 :
                 (wb_ok && (wb_address_input == src2)) ? wb_data_input : regs[src2];

  assign test_selected_reg = ((ZERO_REG != 0) && (test_reg_selector == '0)) ? '0
                                                                            : regs[test_reg_selector];

  assign imm         = {{(DATA_W - IMM_W){inst[IMM_W-1]}}, inst[IMM_W-1:0]};
  assign pc_branched = pc + DATA_W'(1) + imm;

  assign eff_valid = in_valid & ~squash;
  assign dest_hit  = (ex_dest_addr == read1_addr) || (ex_dest_addr == src2);
  assign stall     = ~rst & eff_valid & ex_valid & ex_mem_read & dest_hit & ~dest_zero;
  assign br_perform = ~rst & eff_valid & ~stall & br_comm & (br_mode ? (|read1) : ~(|read1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wb_ok) begin
      regs[wb_address_input] <= wb_data_input;
    end
  end

  // br_perform already excludes stall cycles, so a stall never arms the squash.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      squash   <= 1'b0;
      ex_valid <= 1'b0;
      ex_inst  <= '0;
      ex_read1 <= '0;
      ex_read2 <= '0;
      ex_imm   <= '0;
      ex_pc    <= '0;
    end else begin
      squash <= br_perform;
      if (eff_valid && !stall) begin
        ex_valid <= 1'b1;
        ex_inst  <= inst;
        ex_read1 <= read1;
        ex_read2 <= read2;
        ex_imm   <= imm;
        ex_pc    <= pc;
      end else begin
        ex_valid <= 1'b0;
        ex_inst  <= '0;
        ex_read1 <= '0;
        ex_read2 <= '0;
        ex_imm   <= '0;
        ex_pc    <= '0;
      end
    end
  end

endmodule

`default_nettype wire
